// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_rr_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int SRC_W         = $clog2(DEF_NUM_REQ);

    // Upper bound on requesters supported by the priority helper.
    localparam int MAX_REQ = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Wrap-around priority select: first set bit of req at or above ptr,
    // wrapping to 0. Scanning offsets downward lets the smallest offset win.
    function automatic pick_t rr_pick(input logic [2:0] ptr,
                                      input logic [MAX_REQ-1:0] req,
                                      input int num);
        pick_t      p;
        logic [3:0] sum;
        logic [2:0] idx;
        p = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num) begin
                sum = 4'(ptr) + 4'(i);
                idx = (sum >= 4'(num)) ? 3'(sum - 4'(num)) : 3'(sum);
                if (req[idx]) begin
                    p.found = 1'b1;
                    p.idx   = idx;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester and egress stream bundle for the round-robin arbiter.
interface stream_rr_arbiter_if
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      e_ready_i;
    logic                      e_valid_o;
    logic [DATA_W-1:0]         e_data_o;
    logic                      e_last_o;
    logic [SEL_W-1:0]          e_src_o;

    // Requesters plus egress consumer.
    modport master (
        output req_valid_i, req_data_i, req_last_i, e_ready_i,
        input  req_ready_o, e_valid_o, e_data_o, e_last_o, e_src_o
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_i, req_data_i, req_last_i, e_ready_i,
        output req_ready_o, e_valid_o, e_data_o, e_last_o, e_src_o
    );
endinterface

// File: rtl/stream_skid_stage.sv
// Two-entry registered skid stage: main register drives the output, the
// skid register catches one beat when the output stalls. Ready is a flop.
module stream_skid_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] main_q, skid_q;
    logic         main_vld, skid_vld;
    logic         push, pop;

    // Skid only fills behind a valid main entry, so skid_vld means full.
    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign push      = in_valid && !skid_vld;
    assign pop       = main_vld && out_ready;

    // Refill main from skid first to keep order; otherwise park in skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || pop) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= push;
                if (push) main_q <= in_data;
            end
        end else if (push) begin
            skid_q   <= in_data;
            skid_vld <= 1'b1;
        end
    end
endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one egress stream among NUM_REQ requesters,
// holding each grant for a packet or up to MAX_BURST beats.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic               clk,
    input logic               reset,
    stream_rr_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int PKT_W = DATA_W + 1 + SEL_W;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, grant;
    logic [CNT_W-1:0]   cnt;
    pick_t              pick;
    logic               push_valid, push_ready, accept, rel, last_beat;
    logic [PKT_W-1:0]   push_pkt, pop_pkt;
    logic               pop_valid;

    // Priority scan from the rotating pointer.
    always_comb pick = rr_pick(3'(ptr), MAX_REQ'(bus.req_valid_i), NUM_REQ);

    assign push_valid = (state == ST_GRANT) && bus.req_valid_i[grant];
    assign accept     = push_valid && push_ready;
    assign last_beat  = bus.req_last_i[grant];
    // Release on packet end or on the beat that fills the burst budget.
    assign rel        = accept && (last_beat || cnt == CNT_W'(MAX_BURST - 1));
    assign push_pkt   = {bus.req_data_i[grant*DATA_W +: DATA_W], last_beat, grant};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: arbitrate in IDLE, hold the grant until release.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick.found) state_nxt = ST_GRANT;
            ST_GRANT: if (rel)        state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: only the granted requester sees ready, gated by skid space.
    always_comb begin
        bus.req_ready_o = '0;
        if (state == ST_GRANT) bus.req_ready_o[grant] = push_ready;
    end

    // Grant, beat counter and rotating pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            grant <= '0;
            cnt   <= '0;
        end else if (state == ST_IDLE && pick.found) begin
            grant <= SEL_W'(pick.idx);
            cnt   <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (rel) ptr <= (grant == SEL_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    stream_skid_stage #(.W(PKT_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_data   (push_pkt),
        .out_valid (pop_valid),
        .out_ready (bus.e_ready_i),
        .out_data  (pop_pkt)
    );

    assign bus.e_valid_o = pop_valid;
    assign {bus.e_data_o, bus.e_last_o, bus.e_src_o} = pop_pkt;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: queued requester packets, a
// transaction-level round-robin model, and an egress monitor.
module tb_stream_rr_arbiter;
    import stream_rr_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [7:0] data; logic last; logic [1:0] src; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    stream_rr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    stream_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t          rq[NR][$];
    exp_t           sb[$];
    logic [NR-1:0]  acc;
    int             acc_cnt[NR];
    logic           gap[NR];
    int             pct = 100;
    int             mptr = 0;
    int             n_checks = 0;
    int             n_pass = 0;
    int             cyc = 0;
    logic           check_spacing = 1'b0;
    logic           have_prev = 1'b0;
    int             last_xfer = 0;
    logic           prev_hold = 1'b0;
    logic [10:0]    prev_out;
    exp_t           mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Append one packet of len beats to requester k; returns first beat data.
    task automatic load_pkt(input int k, input int len, output logic [7:0] first);
        beat_t b;
        first = '0;
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.last = (i == len - 1);
            if (i == 0) first = b.data;
            rq[k].push_back(b);
        end
    endtask

    // Reference: whole-transaction round robin over the loaded packet queues.
    task automatic model_run();
        beat_t q[NR][$];
        beat_t b;
        exp_t  e;
        int    g, n;
        logic  found;
        for (int k = 0; k < NR; k++) q[k] = rq[k];
        while (1) begin
            found = 1'b0;
            g = 0;
            for (int off = 0; off < NR; off++)
                if (!found && q[(mptr + off) % NR].size() > 0) begin
                    found = 1'b1;
                    g = (mptr + off) % NR;
                end
            if (!found) break;
            n = 0;
            do begin
                b = q[g].pop_front();
                n++;
                e.data = b.data; e.last = b.last; e.src = 2'(g);
                sb.push_back(e);
            end while (!b.last && n < MB && q[g].size() > 0);
            mptr = (g + 1) % NR;
        end
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (c < 3000 && sb.size() != 0) begin
            @(negedge clk);
            c++;
        end
        check({"drain_", name}, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester/consumer driver: retire accepted beats, present the next.
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset)
            for (int k = 0; k < NR; k++)
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        for (int k = 0; k < NR; k++) begin
            bus.req_valid_i[k] = (rq[k].size() > 0) && !gap[k];
            bus.req_data_i[k*DW +: DW] = (rq[k].size() > 0) ? rq[k][0].data : 8'h00;
            bus.req_last_i[k] = (rq[k].size() > 0) ? rq[k][0].last : 1'b0;
        end
        bus.e_ready_i = (int'($urandom_range(99)) < pct);
    end

    // Monitor: handshakes are decided by values seen at the falling edge.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_hold = 1'b0;
            have_prev = 1'b0;
            acc = '0;
        end else begin
            acc = bus.req_valid_i & bus.req_ready_o;
            for (int k = 0; k < NR; k++) if (acc[k]) acc_cnt[k]++;
            check("ready_onehot", int'($countones(bus.req_ready_o) <= 1), 1);
            if (prev_hold)
                check("hold_stable",
                      int'({bus.e_valid_o, bus.e_data_o, bus.e_last_o, bus.e_src_o}),
                      int'({1'b1, prev_out}));
            if (bus.e_valid_o && bus.e_ready_i) begin
                if (sb.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("egress_data", int'(bus.e_data_o), int'(mon_e.data));
                    check("egress_last", int'(bus.e_last_o), int'(mon_e.last));
                    check("egress_src", int'(bus.e_src_o), int'(mon_e.src));
                    if (check_spacing && have_prev) check("rr_spacing", cyc - last_xfer, 2);
                    have_prev = 1'b1;
                    last_xfer = cyc;
                end
            end
            prev_hold = bus.e_valid_o && !bus.e_ready_i;
            prev_out  = {bus.e_data_o, bus.e_last_o, bus.e_src_o};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0, dd;
        int base, c;
        exp_t e;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.e_ready_i   = 1'b0;
        for (int k = 0; k < NR; k++) begin gap[k] = 1'b0; acc_cnt[k] = 0; end

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("rst_req_ready", int'(bus.req_ready_o), 0);
        check("rst_e_valid", int'(bus.e_valid_o), 0);
        check("rst_e_data", int'(bus.e_data_o), 0);
        check("rst_e_last", int'(bus.e_last_o), 0);
        check("rst_e_src", int'(bus.e_src_o), 0);
        @(negedge clk) reset = 1'b0;

        // Round-robin fairness: single-beat packets, one bubble per grant
        @(negedge clk);
        check_spacing = 1'b1;
        have_prev = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NR; k++) load_pkt(k, 1, dd);
        model_run();
        wait_drain("rr");
        check_spacing = 1'b0;

        // Burst cap: 7-beat packet from 2 is split around requester 3
        @(negedge clk);
        load_pkt(2, 7, dd);
        load_pkt(3, 2, dd);
        model_run();
        wait_drain("burst");

        // Wrap-around from pointer 3 with only 1 and 2 valid
        @(negedge clk);
        load_pkt(1, 2, dd);
        load_pkt(2, 1, dd);
        model_run();
        wait_drain("wrap");

        // Backpressure: two beats fill the skid stage, then ready drops
        pct = 0;
        @(negedge clk);
        #1;
        base = acc_cnt[0];
        load_pkt(0, 4, d0);
        model_run();
        repeat (8) @(negedge clk);
        #1;
        check("bp_accepted", acc_cnt[0] - base, 2);
        check("bp_ready0", int'(bus.req_ready_o[0]), 0);
        check("bp_e_valid", int'(bus.e_valid_o), 1);
        check("bp_e_data", int'(bus.e_data_o), int'(d0));
        pct = 100;
        wait_drain("bp");

        // Reset mid-packet with two beats of requester 1 buffered
        pct = 0;
        @(negedge clk);
        #1;
        base = acc_cnt[1];
        load_pkt(1, 5, dd);
        model_run();
        repeat (8) @(negedge clk);
        #1;
        check("mid_buffered", acc_cnt[1] - base, 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_ready", int'(bus.req_ready_o), 0);
        check("mid_rst_e_valid", int'(bus.e_valid_o), 0);
        check("mid_rst_e_data", int'(bus.e_data_o), 0);
        check("mid_rst_e_last", int'(bus.e_last_o), 0);
        check("mid_rst_e_src", int'(bus.e_src_o), 0);
        for (int k = 0; k < NR; k++) rq[k].delete();
        sb.delete();
        mptr = 0;
        pct = 100;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        load_pkt(3, 1, dd);
        load_pkt(1, 1, dd);
        model_run();
        wait_drain("post_reset");

        // Idle gap: granted requester 1 pauses; requester 0 must wait
        @(negedge clk);
        #1;
        base = acc_cnt[1];
        load_pkt(1, 4, dd);
        for (int i = 0; i < 4; i++) begin
            e.data = rq[1][i].data; e.last = rq[1][i].last; e.src = 2'd1;
            sb.push_back(e);
        end
        c = 0;
        while (acc_cnt[1] == base && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("gap_first_beat", int'(acc_cnt[1] > base), 1);
        gap[1] = 1'b1;
        load_pkt(0, 1, d0);
        e.data = d0; e.last = 1'b1; e.src = 2'd0;
        sb.push_back(e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("gap_ready0", int'(bus.req_ready_o[0]), 0);
        end
        gap[1] = 1'b0;
        mptr = 1;
        wait_drain("gap");

        // Randomized phases against the model
        for (int ph = 0; ph < 8; ph++) begin
            @(negedge clk);
            pct = int'($urandom_range(30, 100));
            for (int k = 0; k < NR; k++) begin
                int np;
                np = int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) load_pkt(k, int'($urandom_range(1, 7)), dd);
            end
            model_run();
            wait_drain("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
